// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI4 read port between ICache (port 0) and DCache (port 1); grant held until r_last, bursts never interleave.
// Latency: AR registered, 1 cycle after a request is seen in IDLE; R path combinational, 0 cycles, unbuffered.
// Backpressure: m_ar_ready stalls in ADDR, rsp_ready of the grantee drives m_r_ready. CACHE_AXI_RD_ARB_RR_EN selects round-robin ties, else DCache wins.
module cache_axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0][7:0]            req_len,
    input  logic [1:0][2:0]            req_size,
    output logic [1:0]                 rsp_valid,
    input  logic [1:0]                 rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic                       rsp_last,
    output logic [1:0]                 rsp_resp,
    output logic                       m_ar_valid,
    input  logic                       m_ar_ready,
    output logic [ADDR_WIDTH-1:0]      m_ar_addr,
    output logic [7:0]                 m_ar_len,
    output logic [2:0]                 m_ar_size,
    output logic [1:0]                 m_ar_burst,
    output logic [ID_WIDTH-1:0]        m_ar_id,
    input  logic                       m_r_valid,
    output logic                       m_r_ready,
    input  logic [DATA_WIDTH-1:0]      m_r_data,
    input  logic                       m_r_last,
    input  logic [1:0]                 m_r_resp,
    input  logic [ID_WIDTH-1:0]        m_r_id
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_e;

    state_e                state_q, state_d;
    logic                  grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]            ar_len_q, ar_len_d;
    logic [2:0]            ar_size_q, ar_size_d;
    logic                  winner;
    logic                  ar_hs;
    logic                  unused_r_id;

    // Routing follows the grant register; the returned id carries no meaning here.
    assign unused_r_id = ^m_r_id;

    assign ar_hs = (state_q == S_ADDR) && m_ar_ready;

`ifdef CACHE_AXI_RD_ARB_RR_EN
    logic rr_ptr_q, rr_ptr_d;

    assign winner   = (&req_valid) ? rr_ptr_q : req_valid[1];
    assign rr_ptr_d = ar_hs ? ~grant_q : rr_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign winner = req_valid[1];
`endif

    assign m_ar_valid = (state_q == S_ADDR);
    assign m_ar_addr  = ar_addr_q;
    assign m_ar_len   = ar_len_q;
    assign m_ar_size  = ar_size_q;
    assign m_ar_burst = 2'b01;
    assign m_ar_id    = {{(ID_WIDTH-1){1'b0}}, grant_q};

    assign rsp_data = m_r_data;
    assign rsp_last = m_r_last;
    assign rsp_resp = m_r_resp;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ar_addr_d = ar_addr_q;
        ar_len_d  = ar_len_q;
        ar_size_d = ar_size_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        m_r_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    state_d   = S_ADDR;
                    grant_d   = winner;
                    ar_addr_d = req_addr[winner];
                    ar_len_d  = req_len[winner];
                    ar_size_d = req_size[winner];
                end
            end
            S_ADDR: begin
                req_ready[grant_q] = m_ar_ready;
                if (ar_hs) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                rsp_valid[grant_q] = m_r_valid;
                m_r_ready          = rsp_ready[grant_q];
                if (m_r_valid && rsp_ready[grant_q] && m_r_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
            ar_size_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ar_addr_q <= ar_addr_d;
            ar_len_q  <= ar_len_d;
            ar_size_q <= ar_size_d;
        end
    end

`ifndef SYNTHESIS
    // An R beat with no burst in flight means the interconnect lost track of an id.
    always_ff @(posedge clk) begin
        if (!rst && m_r_valid) begin
            assert (state_q == S_DATA);
        end
    end
`endif

endmodule
